// File: rtl/armleocpu_tlb_assoc.sv
// armleocpu_tlb_assoc: set-associative TLB held entirely in flip-flops.
// Lookups are registered (one-cycle latency). Writes pick a victim by
// same-key match, then lowest invalid way, then a per-set round-robin pointer.
// Optional feature macro: ARMLEOCPU_TLB_ASID_EN. When defined, entries store an
// ASID that takes part in matching, and INV_ASID runs a multi-cycle walk
// (busy high). When undefined, ASIDs are ignored and INV_ASID acts as INV_ALL.
module armleocpu_tlb_assoc #(
  parameter int ENTRIES_W = 4,
  parameter int WAYS      = 2,
  parameter int ASID_W    = 9,
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        cmd,
  input  logic [19:0]       vaddr,
  input  logic [ASID_W-1:0] asid,
  input  logic [7:0]        new_metadata,
  input  logic [21:0]       new_ptag,
  output logic              busy,
  output logic              resolve_done,
  output logic              hit,
  output logic [7:0]        resolve_metadata,
  output logic [21:0]       resolve_ptag,
  output logic [WAY_W-1:0]  resolve_way
);

  localparam int ENTRIES = 1 << ENTRIES_W;
  localparam int VTAG_W  = 20 - ENTRIES_W;

  localparam logic [2:0] CMD_RESOLVE   = 3'd1;
  localparam logic [2:0] CMD_WRITE     = 3'd2;
  localparam logic [2:0] CMD_INV_ALL   = 3'd3;
  localparam logic [2:0] CMD_INV_VADDR = 3'd4;
  localparam logic [2:0] CMD_INV_ASID  = 3'd5;

  typedef enum logic {IDLE, WALK} state_t;

  // Control state (reset)
  logic             valid_q [WAYS][ENTRIES];
  logic             valid_d [WAYS][ENTRIES];
  logic [WAY_W-1:0] rr_q    [ENTRIES];
  logic [WAY_W-1:0] rr_d    [ENTRIES];
  state_t           state_q, state_d;
  logic             resolve_done_q, resolve_done_d;
  logic             hit_q, hit_d;
  logic [7:0]       meta_out_q, meta_out_d;
  logic [21:0]      ptag_out_q, ptag_out_d;
  logic [WAY_W-1:0] way_out_q, way_out_d;

  // Entry payload (not reset; qualified by valid_q)
  logic [VTAG_W-1:0] vtag_q [WAYS][ENTRIES];
  logic [7:0]        meta_q [WAYS][ENTRIES];
  logic [21:0]       ptag_q [WAYS][ENTRIES];

`ifdef ARMLEOCPU_TLB_ASID_EN
  logic [ASID_W-1:0]    asid_q [WAYS][ENTRIES];
  logic [ASID_W-1:0]    walk_asid_q, walk_asid_d;
  logic [ENTRIES_W-1:0] walk_idx_q, walk_idx_d;
  logic [WAYS-1:0]      asid_eq;
`else
  logic unused_asid;
  assign unused_asid = ^asid;
`endif

  logic [ENTRIES_W-1:0] set_idx;
  logic [VTAG_W-1:0]    req_vtag;
  logic [WAYS-1:0]      lookup_match, same_key, way_invalid;
  logic                 lookup_any;
  logic [WAY_W-1:0]     hit_way, victim;
  logic                 victim_from_rr;
  logic                 write_en;

  assign set_idx  = vaddr[ENTRIES_W-1:0];
  assign req_vtag = vaddr[19:ENTRIES_W];
  assign write_en = (state_q == IDLE) && (cmd == CMD_WRITE);

  // Per-way compare of the indexed set against the request
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      way_invalid[w] = !valid_q[w][set_idx];
`ifdef ARMLEOCPU_TLB_ASID_EN
      asid_eq[w]      = (asid_q[w][set_idx] == asid);
      lookup_match[w] = valid_q[w][set_idx] && (vtag_q[w][set_idx] == req_vtag) &&
                        (meta_q[w][set_idx][5] || asid_eq[w]);
      same_key[w]     = valid_q[w][set_idx] && (vtag_q[w][set_idx] == req_vtag) && asid_eq[w];
`else
      lookup_match[w] = valid_q[w][set_idx] && (vtag_q[w][set_idx] == req_vtag);
      same_key[w]     = lookup_match[w];
`endif
    end
  end

  // Lowest matching way for lookup; victim priority same-key > invalid > round-robin
  always_comb begin
    hit_way        = '0;
    lookup_any     = 1'b0;
    victim         = rr_q[set_idx];
    victim_from_rr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (lookup_match[w]) begin
        hit_way    = WAY_W'(w);
        lookup_any = 1'b1;
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_invalid[w]) begin
        victim         = WAY_W'(w);
        victim_from_rr = 1'b0;
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (same_key[w]) begin
        victim         = WAY_W'(w);
        victim_from_rr = 1'b0;
      end
    end
  end

  // Command decode and next-state for valid bits, pointers, FSM and lookup outputs
  always_comb begin
    valid_d        = valid_q;
    rr_d           = rr_q;
    state_d        = state_q;
    resolve_done_d = 1'b0;
    hit_d          = hit_q;
    meta_out_d     = meta_out_q;
    ptag_out_d     = ptag_out_q;
    way_out_d      = way_out_q;
`ifdef ARMLEOCPU_TLB_ASID_EN
    walk_asid_d    = walk_asid_q;
    walk_idx_d     = walk_idx_q;
`endif
    if (state_q == WALK) begin
`ifdef ARMLEOCPU_TLB_ASID_EN
      if (cmd == CMD_INV_ALL) begin
        for (int w = 0; w < WAYS; w++)
          for (int s = 0; s < ENTRIES; s++) valid_d[w][s] = 1'b0;
        for (int s = 0; s < ENTRIES; s++) rr_d[s] = '0;
        state_d = IDLE;
      end else begin
        for (int w = 0; w < WAYS; w++) begin
          if (!meta_q[w][walk_idx_q][5] && (asid_q[w][walk_idx_q] == walk_asid_q))
            valid_d[w][walk_idx_q] = 1'b0;
        end
        walk_idx_d = walk_idx_q + 1'b1;
        if (walk_idx_q == ENTRIES_W'(ENTRIES - 1)) state_d = IDLE;
      end
`endif
    end else begin
      case (cmd)
        CMD_RESOLVE: begin
          resolve_done_d = 1'b1;
          hit_d          = lookup_any;
          meta_out_d     = lookup_any ? meta_q[hit_way][set_idx] : 8'd0;
          ptag_out_d     = lookup_any ? ptag_q[hit_way][set_idx] : 22'd0;
          way_out_d      = lookup_any ? hit_way : '0;
        end
        CMD_WRITE: begin
          valid_d[victim][set_idx] = new_metadata[0];
          if (victim_from_rr)
            rr_d[set_idx] = (rr_q[set_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[set_idx] + 1'b1;
        end
        CMD_INV_VADDR: begin
          for (int w = 0; w < WAYS; w++)
            if (lookup_match[w]) valid_d[w][set_idx] = 1'b0;
        end
`ifdef ARMLEOCPU_TLB_ASID_EN
        CMD_INV_ASID: begin
          state_d     = WALK;
          walk_idx_d  = '0;
          walk_asid_d = asid;
        end
        CMD_INV_ALL: begin
`else
        CMD_INV_ALL, CMD_INV_ASID: begin
`endif
          for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < ENTRIES; s++) valid_d[w][s] = 1'b0;
          for (int s = 0; s < ENTRIES; s++) rr_d[s] = '0;
        end
        default: ;
      endcase
    end
  end

  // Control registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < ENTRIES; s++) valid_q[w][s] <= 1'b0;
      for (int s = 0; s < ENTRIES; s++) rr_q[s] <= '0;
      state_q        <= IDLE;
      resolve_done_q <= 1'b0;
      hit_q          <= 1'b0;
      meta_out_q     <= '0;
      ptag_out_q     <= '0;
      way_out_q      <= '0;
`ifdef ARMLEOCPU_TLB_ASID_EN
      walk_asid_q    <= '0;
      walk_idx_q     <= '0;
`endif
    end else begin
      valid_q        <= valid_d;
      rr_q           <= rr_d;
      state_q        <= state_d;
      resolve_done_q <= resolve_done_d;
      hit_q          <= hit_d;
      meta_out_q     <= meta_out_d;
      ptag_out_q     <= ptag_out_d;
      way_out_q      <= way_out_d;
`ifdef ARMLEOCPU_TLB_ASID_EN
      walk_asid_q    <= walk_asid_d;
      walk_idx_q     <= walk_idx_d;
`endif
    end
  end

  // Entry payload written into the chosen victim way
  always_ff @(posedge clk) begin
    if (write_en) begin
      vtag_q[victim][set_idx] <= req_vtag;
      meta_q[victim][set_idx] <= new_metadata;
      ptag_q[victim][set_idx] <= new_ptag;
`ifdef ARMLEOCPU_TLB_ASID_EN
      asid_q[victim][set_idx] <= asid;
`endif
    end
  end

  assign busy             = (state_q == WALK);
  assign resolve_done     = resolve_done_q;
  assign hit              = hit_q;
  assign resolve_metadata = meta_out_q;
  assign resolve_ptag     = ptag_out_q;
  assign resolve_way      = way_out_q;

endmodule
